seg7_decode_monitor: RTL and testbench

// - Inverse of the hex-to-7-segment encoder: samples an active-low 7-segment pattern (bit order 6543210)
//   and recovers the 4-bit hex nibble it shows, with blank and invalid flags.
// - A stability filter ignores glitches and mid-update patterns; only steady patterns are committed.
// - Sits on any HEX output bus, or on a board/bench loopback, so displayed values can be read back
//   and checked against RAM data/address in hardware.

---
 rtl/seg7_decode_monitor.sv | 220 ++++++++++++++++++++++
 tb/tb_seg7_decode_monitor.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_decode_monitor.sv
// -----------------------------------------------------------------------------
// seg7_decode_monitor
//
// Purpose:
//   Reads back an active-low 7-segment pattern (bit order 6543210) and recovers
//   the hex nibble it shows. A stability filter commits a pattern only after it
//   has persisted for STABLE_CYCLES consecutive enabled samples, so glitches and
//   mid-update patterns on the HEX bus are ignored.
//
// Parameters:
//   STABLE_CYCLES  consecutive enabled samples before commit (>= 1)
//   ERR_W          width of the saturating invalid-commit counter
//
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   seg_in       in   [6:0] observed segment pattern, active-low
//   sample_en    in   1 = filter advances, 0 = filter frozen
//   err_clr      in   synchronous clear of err_count
//   nibble       out  [3:0] decoded value of the committed pattern
//   blank        out  committed pattern is all segments off
//   invalid      out  committed pattern is neither hex nor blank
//   valid_pulse  out  one-cycle strobe when a new pattern is committed
//   err_count    out  [ERR_W-1:0] saturating count of invalid commits
//
// Build option:
//   ERR_COUNT_EN  when defined, err_count counts invalid commits; otherwise
//                 err_count is tied to zero and err_clr is ignored.
// -----------------------------------------------------------------------------
module seg7_decode_monitor #(
   parameter int STABLE_CYCLES = 4,
   parameter int ERR_W         = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [6:0]       seg_in,
   input  logic             sample_en,
   input  logic             err_clr,
   output logic [3:0]       nibble,
   output logic             blank,
   output logic             invalid,
   output logic             valid_pulse,
   output logic [ERR_W-1:0] err_count
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [6:0]       SEG_BLANK = 7'h7F;

   typedef enum logic {
      LOCKED   = 1'b0,
      SETTLING = 1'b1
   } state_e;

   // Returns {invalid, blank, nibble} for an active-low segment pattern.
   function automatic logic [5:0] decode_seg(input logic [6:0] p);
      logic [5:0] r;
      r = 6'b10_0000;
      case (p)
         7'b1000000: r = {2'b00, 4'h0};
         7'b1111001: r = {2'b00, 4'h1};
         7'b0100100: r = {2'b00, 4'h2};
         7'b0110000: r = {2'b00, 4'h3};
         7'b0011001: r = {2'b00, 4'h4};
         7'b0010010: r = {2'b00, 4'h5};
         7'b0000010: r = {2'b00, 4'h6};
         7'b1111000: r = {2'b00, 4'h7};
         7'b0000000: r = {2'b00, 4'h8};
         7'b0011000: r = {2'b00, 4'h9};
         7'b0001000: r = {2'b00, 4'hA};
         7'b0000011: r = {2'b00, 4'hB};
         7'b1000110: r = {2'b00, 4'hC};
         7'b0100001: r = {2'b00, 4'hD};
         7'b0000110: r = {2'b00, 4'hE};
         7'b0001110: r = {2'b00, 4'hF};
         7'b1111111: r = 6'b01_0000;
         default:    r = 6'b10_0000;
      endcase
      return r;
   endfunction

   logic [6:0]       seg_q;
   logic [6:0]       cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [6:0]       committed_q, committed_d;
   state_e           state_q, state_d;
   logic [3:0]       nibble_q, nibble_d;
   logic             blank_q, blank_d;
   logic             invalid_q, invalid_d;
   logic             valid_q, valid_d;

   logic [5:0]       dec;
   logic             load;
   logic             reach;
   logic             commit;

   always_comb begin
      dec    = decode_seg(seg_q);
      load   = sample_en && (seg_q != cand_q);
      reach  = 1'b0;
      commit = 1'b0;

      // A reload sets cnt to 1, which only completes the run when one
      // sample is enough; otherwise the run completes on the increment
      // from STABLE_CYCLES-1.
      if (load) begin
         reach = (STABLE_CYCLES == 1);
      end else begin
         reach = (cnt_q == CNT_PRE);
      end

      // While locked the candidate equals the committed pattern, so a run
      // completing without a reload can only commit in SETTLING.
      if (sample_en && reach) begin
         if (load) begin
            commit = (seg_q != committed_q);
         end else begin
            commit = (state_q == SETTLING);
         end
      end

      cand_d      = cand_q;
      cnt_d       = cnt_q;
      committed_d = committed_q;
      nibble_d    = nibble_q;
      blank_d     = blank_q;
      invalid_d   = invalid_q;
      valid_d     = commit;

      if (load) begin
         cand_d = seg_q;
         cnt_d  = CNT_W'(1);
      end else if (sample_en && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      if (commit) begin
         committed_d = seg_q;
         invalid_d   = dec[5];
         blank_d     = dec[4];
         nibble_d    = dec[3:0];
      end

      state_d = state_q;
      case (state_q)
         LOCKED: begin
            if (load && !commit) begin
               state_d = SETTLING;
            end
         end
         SETTLING: begin
            // Candidate falling back onto the committed pattern absorbs the
            // glitch without a pulse.
            if (commit || (load && (seg_q == committed_q))) begin
               state_d = LOCKED;
            end
         end
         default: state_d = LOCKED;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seg_q       <= SEG_BLANK;
         cand_q      <= SEG_BLANK;
         cnt_q       <= '0;
         committed_q <= SEG_BLANK;
         state_q     <= LOCKED;
         nibble_q    <= 4'h0;
         blank_q     <= 1'b1;
         invalid_q   <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         seg_q       <= seg_in;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         committed_q <= committed_d;
         state_q     <= state_d;
         nibble_q    <= nibble_d;
         blank_q     <= blank_d;
         invalid_q   <= invalid_d;
         valid_q     <= valid_d;
      end
   end

   assign nibble      = nibble_q;
   assign blank       = blank_q;
   assign invalid     = invalid_q;
   assign valid_pulse = valid_q;

`ifdef ERR_COUNT_EN
   logic [ERR_W-1:0] err_q, err_d;

   // Clear takes priority over an increment on the same edge.
   always_comb begin
      err_d = err_q;
      if (err_clr) begin
         err_d = '0;
      end else if (commit && dec[5] && (err_q != {ERR_W{1'b1}})) begin
         err_d = err_q + ERR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_q <= '0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_count = err_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign err_count      = '0;
`endif

endmodule

// File: tb/tb_seg7_decode_monitor.sv
module tb_seg7_decode_monitor;

   localparam int S     = 4;
   localparam int S2    = 1;
`ifdef ERR_COUNT_EN
   localparam bit ERR_ON = 1'b1;
`else
   localparam bit ERR_ON = 1'b0;
`endif

   localparam logic [6:0] P1  = 7'b1111001;
   localparam logic [6:0] P2  = 7'b0100100;
   localparam logic [6:0] P3  = 7'b0110000;
   localparam logic [6:0] P5  = 7'b0010010;
   localparam logic [6:0] P7  = 7'b1111000;
   localparam logic [6:0] PBL = 7'b1111111;
   localparam logic [6:0] PX1 = 7'b1010101;
   localparam logic [6:0] PX2 = 7'b0101010;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [6:0] seg_in = 7'h7F;
   logic       sample_en = 1'b0;
   logic       err_clr = 1'b0;
   logic [3:0] nibble;
   logic       blank, invalid, valid_pulse;
   logic [7:0] err_count;

   logic       rst2_n = 1'b0;
   logic [6:0] seg2 = 7'h7F;
   logic       en2 = 1'b1;
   logic       clr2 = 1'b0;
   logic [3:0] nibble2;
   logic       blank2, invalid2, pulse2;
   logic [1:0] err2;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   seg7_decode_monitor #(.STABLE_CYCLES(S), .ERR_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .seg_in(seg_in), .sample_en(sample_en),
      .err_clr(err_clr), .nibble(nibble), .blank(blank), .invalid(invalid),
      .valid_pulse(valid_pulse), .err_count(err_count)
   );

   seg7_decode_monitor #(.STABLE_CYCLES(S2), .ERR_W(2)) dut2 (
      .clk(clk), .reset_n(rst2_n), .seg_in(seg2), .sample_en(en2),
      .err_clr(clr2), .nibble(nibble2), .blank(blank2), .invalid(invalid2),
      .valid_pulse(pulse2), .err_count(err2)
   );

   // ---------------- reference model ----------------
   logic [6:0] hex_pat [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   logic [6:0] m_segq, m_comm;
   logic [6:0] m_hist[$];
   logic [3:0] m_nib;
   logic       m_blank, m_inv, m_pulse;
   int         m_err;

   task automatic model_reset();
      m_segq = 7'h7F; m_comm = 7'h7F; m_hist.delete();
      m_nib = 4'h0; m_blank = 1'b1; m_inv = 1'b0; m_pulse = 1'b0; m_err = 0;
   endtask

   // A pattern commits when exactly the last S enabled samples agree on it
   // and it differs from what is already committed.
   task automatic model_edge(input logic [6:0] s, input logic en, input logic clr);
      int run;
      m_pulse = 1'b0;
      if (en) begin
         m_hist.push_back(m_segq);
         if (m_hist.size() > S + 1) void'(m_hist.pop_front());
         run = 0;
         for (int i = m_hist.size() - 1; i >= 0; i--) begin
            if (m_hist[i] == m_hist[m_hist.size()-1]) run++;
            else break;
         end
         if (run == S && m_hist[m_hist.size()-1] != m_comm) begin
            m_comm = m_hist[m_hist.size()-1];
            m_pulse = 1'b1;
            m_nib = 4'h0; m_blank = (m_comm == 7'h7F); m_inv = !m_blank;
            for (int k = 0; k < 16; k++) begin
               if (hex_pat[k] == m_comm) begin
                  m_nib = 4'(k); m_inv = 1'b0;
               end
            end
            if (ERR_ON && m_inv && m_err < 255) m_err++;
         end
      end
      if (ERR_ON && clr) m_err = 0;
      m_segq = s;
   endtask

   // ---------------- helpers ----------------
   function automatic logic [31:0] pack(input logic [3:0] n, input logic b, input logic i,
                                        input logic p, input int e);
      return {17'b0, n, b, i, p, e[7:0]};
   endfunction

   function automatic logic [31:0] dut_out();
      return {17'b0, nibble, blank, invalid, valid_pulse, err_count};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %h (nib,blk,inv,pls,err) required %h", name, got, exp);
      end
   endtask

   task automatic tick(input logic [6:0] s, input logic en, input logic clr);
      seg_in = s; sample_en = en; err_clr = clr;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; seg_in = 7'h7F; sample_en = 1'b1; err_clr = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;
      model_reset();
   endtask

   typedef struct {
      logic [6:0] seg;
      logic       en;
      logic       clr;
      logic [3:0] nib;
      logic       blank;
      logic       inv;
      logic       pulse;
      int         err;
   } vec_t;

   vec_t vecs[$];

   task automatic addn(input int n, input logic [6:0] s, input logic clr, input logic [3:0] nb,
                       input logic b, input logic i, input logic p, input int e);
      vec_t v;
      v.seg = s; v.en = 1'b1; v.clr = clr; v.nib = nb; v.blank = b; v.inv = i; v.pulse = p;
      v.err = e;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endtask

   function automatic logic [6:0] rand_pat();
      int r;
      logic [6:0] p;
      r = $urandom_range(0, 99);
      if (r < 50)      p = hex_pat[$urandom_range(0, 15)];
      else if (r < 65) p = 7'h7F;
      else             p = 7'($urandom_range(0, 127));
      return p;
   endfunction

   initial begin
      int e1;
      e1 = ERR_ON ? 1 : 0;

      // ---------------- table-driven directed sequence ----------------
      addn(4, P2,  1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 0);
      addn(1, P2,  1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 0);
      addn(1, P2,  1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 0);
      addn(3, P1,  1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 0);
      addn(5, P2,  1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 0);
      addn(4, PBL, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 0);
      addn(1, PBL, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 0);
      addn(1, PBL, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 0);
      addn(4, PX1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 0);
      addn(1, PX1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, e1);
      addn(5, PX1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, e1);
      addn(4, PX2, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, e1);
      addn(1, PX2, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 0);
      addn(1, PX2, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 0);

      do_reset();
      check("reset_state", dut_out(), pack(4'h0, 1'b1, 1'b0, 1'b0, 0));
      check("reset_state_w2", {28'b0, blank2, invalid2, pulse2, err2[0] | err2[1]}, 32'h8);

      for (int i = 0; i < vecs.size(); i++) begin
         tick(vecs[i].seg, vecs[i].en, vecs[i].clr);
         check($sformatf("vec%0d", i), dut_out(),
               pack(vecs[i].nib, vecs[i].blank, vecs[i].inv, vecs[i].pulse, vecs[i].err));
      end

      // ---------------- freeze mid-settle ----------------
      do_reset();
      for (int i = 0; i < 2; i++) tick(P3, 1'b1, 1'b0);
      check("freeze_pre", dut_out(), pack(4'h0, 1'b1, 1'b0, 1'b0, 0));
      for (int i = 0; i < 6; i++) begin
         tick(P3, 1'b0, 1'b0);
         check($sformatf("freeze_hold%0d", i), dut_out(), pack(4'h0, 1'b1, 1'b0, 1'b0, 0));
      end
      tick(P3, 1'b1, 1'b0);
      tick(P3, 1'b1, 1'b0);
      check("freeze_resume2", dut_out(), pack(4'h0, 1'b1, 1'b0, 1'b0, 0));
      tick(P3, 1'b1, 1'b0);
      check("freeze_commit3", dut_out(), pack(4'h3, 1'b0, 1'b0, 1'b1, 0));

      // ---------------- async reset mid-settle ----------------
      for (int i = 0; i < 5; i++) tick(P5, 1'b1, 1'b0);
      check("pre_rst_commit", dut_out(), pack(4'h5, 1'b0, 1'b0, 1'b1, 0));
      for (int i = 0; i < 3; i++) tick(P7, 1'b1, 1'b0);
      #2 reset_n = 1'b0;
      #1 check("async_reset", dut_out(), pack(4'h0, 1'b1, 1'b0, 1'b0, 0));
      @(posedge clk); #1 reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick(P7, 1'b1, 1'b0);
         check($sformatf("post_rst%0d", i), dut_out(), pack(4'h0, 1'b1, 1'b0, 1'b0, 0));
      end
      tick(P7, 1'b1, 1'b0);
      check("post_rst_commit", dut_out(), pack(4'h7, 1'b0, 1'b0, 1'b1, 0));

      // ---------------- ERR_W=2, STABLE_CYCLES=1 saturation ----------------
      rst2_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         int exp_e;
         seg2 = (k % 2 == 0) ? PX1 : PX2;
         @(posedge clk); #1;
         check($sformatf("w2_load%0d", k), {31'b0, pulse2}, 32'h0);
         @(posedge clk); #1;
         exp_e = ERR_ON ? ((k + 1 > 3) ? 3 : k + 1) : 0;
         check($sformatf("w2_commit%0d", k), {27'b0, invalid2, pulse2, blank2, err2},
               {27'b0, 1'b1, 1'b1, 1'b0, 2'(exp_e)});
      end

      // ---------------- randomized against model ----------------
      do_reset();
      begin
         logic [6:0] p;
         int hold;
         int cyc;
         cyc = 0;
         while (cyc < 1500) begin
            p = rand_pat();
            hold = $urandom_range(1, 7);
            for (int h = 0; h < hold; h++) begin
               logic en, clr;
               en  = ($urandom_range(0, 9) != 0);
               clr = ($urandom_range(0, 31) == 0);
               tick(p, en, clr);
               model_edge(p, en, clr);
               check($sformatf("rand%0d", cyc), dut_out(),
                     pack(m_nib, m_blank, m_inv, m_pulse, m_err));
               cyc++;
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
